hilo_mdu: RTL
=============

# hilo_mdu

Parametrised HI/LO unit for the execute stage. It holds the HI and LO registers and runs multi-cycle multiply and divide operations. Results are written to HI/LO in a single writeback, and a busy/done handshake lets the pipeline control stall younger mfhi/mflo/mult/div instructions. It replaces the fixed-width, single-cycle-write HI/LO register and adds signed/unsigned iterative divide, a pipelined multiply, and exception flush.

## Interface
- WIDTH, 32, data width; HI and LO are each WIDTH bits.
- MUL_LAT, 2, multiply latency in cycles (legal 1..4).

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- op_valid_i  in  1  operation request; sampled only when busy_o=0.
- op_i  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as NOP.
- src_a_i  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b_i  in  WIDTH  rt operand (divisor / multiplier).
- flush_i  in  1  exception/branch flush; aborts any in-flight or same-cycle op.
- rd_sel_i  in  1  0 = read HI, 1 = read LO.
- rd_data_o  out  WIDTH  combinational read of the selected register.
- busy_o  out  1  multi-cycle op in flight; registered.
- done_o  out  1  one-cycle pulse in the cycle the HI/LO writeback occurs.

## Operation
- State machine:
  - IDLE: accept when op_valid_i & ~busy_o & ~flush_i.
    - MTHI/MTLO write src_a_i to HI/LO at the next edge and stay in IDLE. busy_o stays 0 and done_o stays 0.
    - MULT* and MADD/MSUB family go to MUL, with a counter loaded to MUL_LAT.
    - DIV* goes to DIV.
    - NOP and illegal ops do nothing.
  - MUL: the product is 2*WIDTH bits, signed for MULT/MADD/MSUB and unsigned for the U forms. The operand/product pipeline advances each cycle. In the last cycle, {HI,LO} is written and the unit returns to IDLE.
  - DIV:
    - Cycle 1 latches absolute values (signed ops) or raw values (unsigned).
    - If the divisor is 0, the unit returns to IDLE immediately: done_o pulses and HI/LO are unchanged.
    - Otherwise it runs WIDTH restoring radix-2 iterations, then one sign-fix cycle that writes LO=quotient and HI=remainder.
    - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
    - Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- Accumulate ops (with macro):
  - MADD/MADDU: {HI,LO} <= {HI,LO} + product.
  - MSUB/MSUBU: {HI,LO} <= {HI,LO} - product.
  - Modulo 2^(2*WIDTH). The {HI,LO} value used is the one at writeback.
- Flush:
  - flush_i in MUL or DIV returns the unit to IDLE at the next edge, with no write and no done_o.
  - Flush wins over a writeback in the same cycle.
  - Flush in the acceptance cycle blocks acceptance, including for MTHI/MTLO.
- Reads: rd_data_o always reflects the current register contents. There is no forwarding from an in-flight op; the pipeline must stall on busy_o.

## Timing
- Reset: HI=0, LO=0, state IDLE, busy_o=0, done_o=0, counters cleared. Reset mid-operation abandons the op with no write.
- MTHI/MTLO accepted in cycle T: value visible on rd_data_o in T+1.
- Multiply accepted in T:
  - busy_o=1 in T+1..T+MUL_LAT.
  - done_o=1 and the write take effect at the end of T+MUL_LAT.
  - Result readable in T+MUL_LAT+1.
- Divide accepted in T:
  - busy_o=1 in T+1..T+WIDTH+2.
  - done_o in T+WIDTH+2.
  - Result readable in T+WIDTH+3.
- Divide by zero accepted in T: busy_o=1 and done_o=1 only in T+1.
- busy_o falls in the cycle after done_o, so a new op can be accepted in that cycle (back-to-back).

## Configuration
- HILO_MADD_EN:
  - Defined: op codes 7-10 perform accumulate as above.
  - Undefined: op codes 7-10 are treated as NOP, the accumulate adder is removed, and busy_o/done_o are unaffected.

## Test plan
- Reset: assert rst 2 cycles -> HI=LO=0 on both rd_sel_i values, busy_o=0, done_o=0.
- MULT a=0xFFFFFFFD, b=7 (WIDTH=32, MUL_LAT=2) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, done_o in T+2. MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, done_o in T+34. DIVU 0xFFFFFFF9/2 -> LO=0x7FFFFFFC, HI=0x00000001.
- DIV x/0 after MTHI 0x12345678 -> done_o in T+1, HI stays 0x12345678. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV started, flush_i in T+10 -> busy_o=0 in T+11, done_o never pulses, HI/LO unchanged. MTHI with flush_i in the same cycle -> no write.
- With HILO_MADD_EN: HI:LO=0:5, MADD 2,3 -> LO=11; then MSUBU 4,4 -> HI=0xFFFFFFFF, LO=0xFFFFFFFB. Without the macro, op 7 -> no busy, no write.

Source files
------------

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO register pair with pipelined multiply and iterative
// restoring divide for the execute stage. A busy/done handshake lets the
// pipeline stall younger HI/LO consumers.
// Optional feature macro HILO_MADD_EN: enables MADD/MADDU/MSUB/MSUBU
// (op codes 7-10); when undefined those codes decode as NOP.
module hilo_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             rd_sel_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + MUL_LAT + 1);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DLATCH,
    S_DITER,
    S_DFIX
  } state_e;

`ifdef HILO_MADD_EN
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_e;
  acc_e acc_q;
  acc_e dec_acc;
`endif

  state_e           state_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             sgn_q;
  logic             negq_q;
  logic             negr_q;

  logic             dec_mul;
  logic             dec_div;
  logic             dec_mthi;
  logic             dec_mtlo;
  logic             dec_sgn;

  logic [DW-1:0]    a_ext;
  logic [DW-1:0]    b_ext;
  logic [DW-1:0]    prod_c;
  logic [DW-1:0]    mul_res;
  logic [DW-1:0]    mul_wb;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             wb_cycle;

  // Opcode decode for the acceptance cycle
  always_comb begin
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    dec_mthi = 1'b0;
    dec_mtlo = 1'b0;
    dec_sgn  = 1'b0;
`ifdef HILO_MADD_EN
    dec_acc  = ACC_NONE;
`endif
    case (op_i)
      OP_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
      OP_MULTU: dec_mul = 1'b1;
      OP_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
      OP_DIVU:  dec_div = 1'b1;
      OP_MTHI:  dec_mthi = 1'b1;
      OP_MTLO:  dec_mtlo = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_ADD; end
      OP_MADDU: begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
      OP_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_SUB; end
      OP_MSUBU: begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  // Full-width product: sign/zero extend to 2*WIDTH so the truncated
  // unsigned multiply yields the correct low 2*WIDTH bits for both forms
  always_comb begin
    a_ext  = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext  = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_c = a_ext * b_ext;
  end

  // Product pipeline: MUL_LAT-1 register stages after the multiplier
  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_res = prod_c;
  end else if (MUL_LAT == 2) begin : g_mul_one
    logic [DW-1:0] pipe_q;
    // Single product stage
    always_ff @(posedge clk) pipe_q <= prod_c;
    assign mul_res = pipe_q;
  end else begin : g_mul_multi
    localparam int unsigned PW = (MUL_LAT - 1) * DW;
    logic [PW-1:0] pipe_q;
    // Shift products toward the top stage, newest enters at the bottom
    always_ff @(posedge clk) pipe_q <= {pipe_q[PW-DW-1:0], prod_c};
    assign mul_res = pipe_q[PW-1 -: DW];
  end

  // Multiply writeback value, optionally accumulated into current {HI,LO}
  always_comb begin
    mul_wb = mul_res;
`ifdef HILO_MADD_EN
    case (acc_q)
      ACC_ADD: mul_wb = {hi_q, lo_q} + mul_res;
      ACC_SUB: mul_wb = {hi_q, lo_q} - mul_res;
      default: ;
    endcase
`endif
  end

  // Divide datapath: operand magnitudes and one restoring iteration
  always_comb begin
    a_abs    = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    rem_sh   = {rem_q, a_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
  end

  // Writeback-cycle detect; flush suppresses the done pulse
  always_comb begin
    wb_cycle = 1'b0;
    case (state_q)
      S_MUL:    wb_cycle = (cnt_q == CW'(1));
      S_DLATCH: wb_cycle = (b_q == '0);
      S_DFIX:   wb_cycle = 1'b1;
      default:  wb_cycle = 1'b0;
    endcase
    done_o = wb_cycle & ~flush_i;
  end

  // Control FSM with HI/LO and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid_i && !flush_i) begin
            if (dec_mthi) hi_q <= src_a_i;
            if (dec_mtlo) lo_q <= src_a_i;
            if (dec_mul || dec_div) begin
              a_q     <= src_a_i;
              b_q     <= src_b_i;
              sgn_q   <= dec_sgn;
              busy_q  <= 1'b1;
`ifdef HILO_MADD_EN
              acc_q   <= dec_acc;
`endif
              if (dec_mul) begin
                state_q <= S_MUL;
                cnt_q   <= CW'(MUL_LAT);
              end else begin
                state_q <= S_DLATCH;
                cnt_q   <= CW'(WIDTH);
              end
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(1)) begin
            {hi_q, lo_q} <= mul_wb;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DLATCH: begin
          if (flush_i || b_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            // a_q becomes the quotient shift register, b_q the divisor.
            // Most-negative / -1 needs no special case: the magnitude
            // 2^(WIDTH-1) fits unsigned and the signs match, so LO ends
            // at most-negative and HI at zero.
            a_q     <= a_abs;
            b_q     <= b_abs;
            rem_q   <= '0;
            negq_q  <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            negr_q  <= sgn_q & a_q[WIDTH-1];
            cnt_q   <= CW'(WIDTH);
            state_q <= S_DITER;
          end
        end
        S_DITER: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (!rem_diff[WIDTH]) begin
              rem_q <= rem_diff[WIDTH-1:0];
              a_q   <= {a_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh[WIDTH-1:0];
              a_q   <= {a_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= S_DFIX;
          end
        end
        S_DFIX: begin
          if (!flush_i) begin
            lo_q <= negq_q ? -a_q : a_q;
            hi_q <= negr_q ? -rem_q : rem_q;
          end
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign rd_data_o = rd_sel_i ? lo_q : hi_q;

endmodule
